// File: rtl/mm_seq.sv
// rtl/mm_seq.sv - matrix-multiply tile sequencer; optional PPU-stall counter under MM_SEQ_PERF_EN
`ifndef INT4_VSQ
`define INT4_VSQ 2'd3
`endif

module mm_seq #(
  parameter int B_STEPS   = 16,
  parameter int K_STEPS   = 4,
  parameter int ROW_MAX   = 32,
  parameter int COL_MAX   = 32,
  parameter int B_KSTRIDE = 512,
  parameter int A_AW      = 7,
  parameter int B_AW      = 11
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [1:0]                   i_mode,
  input  logic [$clog2(ROW_MAX)-1:0]   i_row_tiles,
  input  logic [$clog2(COL_MAX)-1:0]   i_col_tiles,
  input  logic                         i_abort,
  input  logic                         i_ppu_ready,
  output logic                         o_busy,
  output logic [1:0]                   o_mode,
  output logic                         o_findmax,
  output logic [A_AW-1:0]              o_a_addr,
  output logic [B_AW-1:0]              o_b_addr,
  output logic                         o_mac_en,
  output logic                         o_psum_clr,
  output logic                         o_acc_we,
  output logic [$clog2(B_STEPS)-1:0]   o_acc_addr,
  output logic                         o_ppu_start,
  output logic                         o_tile_done,
  output logic                         o_mtrx_done,
  output logic [31:0]                  o_stall_cnt
);

  localparam int BW = $clog2(B_STEPS);
  localparam int KW = $clog2(K_STEPS);
  localparam int RW = $clog2(ROW_MAX);
  localparam int CW = $clog2(COL_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAX  = 2'd1,
    CALC = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   b_cnt;
  logic [KW-1:0]   a_cnt;
  logic [CW-1:0]   col_cnt;
  logic [RW-1:0]   row_cnt;
  logic [1:0]      mode_q;
  logic [RW-1:0]   row_tiles_q;
  logic [CW-1:0]   col_tiles_q;
  logic            ppu_start_q;
  logic            tile_done_q;
  logic            mtrx_done_q;

  logic busy, b_last, a_last, col_last, row_last, at_l, issue, start_go, final_step;

  assign busy       = (state != IDLE);
  assign b_last     = (b_cnt == BW'(B_STEPS - 1));
  assign a_last     = (a_cnt == KW'(K_STEPS - 1));
  assign col_last   = (col_cnt == col_tiles_q);
  assign row_last   = (row_cnt == row_tiles_q);
  assign at_l       = b_last && a_last;
  // The last step of a tile waits for the PPU; every other step issues unconditionally.
  assign issue      = busy && !(at_l && !i_ppu_ready);
  assign start_go   = (state == IDLE) && i_start && !i_abort;
  assign final_step = issue && at_l && col_last && row_last;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_nxt = state;
    if (i_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (i_start) state_nxt = (i_mode == `INT4_VSQ) ? CALC : MAX;
        MAX:  if (final_step) state_nxt = CALC;
        CALC: if (final_step) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Job parameters are captured once per start so the caller may change them mid-job.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q      <= '0;
      row_tiles_q <= '0;
      col_tiles_q <= '0;
    end else if (start_go) begin
      mode_q      <= i_mode;
      row_tiles_q <= i_row_tiles;
      col_tiles_q <= i_col_tiles;
    end
  end

  // Nested step counters; the final step wraps every counter, which also rearms MAX->CALC.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort || start_go) begin
      b_cnt   <= '0;
      a_cnt   <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (issue) begin
      if (!b_last) begin
        b_cnt <= b_cnt + 1'b1;
      end else begin
        b_cnt <= '0;
        if (!a_last) begin
          a_cnt <= a_cnt + 1'b1;
        end else begin
          a_cnt <= '0;
          if (!col_last) begin
            col_cnt <= col_cnt + 1'b1;
          end else begin
            col_cnt <= '0;
            row_cnt <= row_last ? '0 : row_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Completion pulses, registered one cycle after the last step of a tile issues.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      ppu_start_q <= 1'b0;
      tile_done_q <= 1'b0;
      mtrx_done_q <= 1'b0;
    end else begin
      ppu_start_q <= issue && at_l;
      tile_done_q <= issue && at_l && (state == CALC);
      mtrx_done_q <= final_step && (state == CALC);
    end
  end

`ifdef MM_SEQ_PERF_EN
  logic [31:0] stall_q;

  // Counts cycles lost waiting on the PPU at the last step; saturates rather than wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || start_go) begin
      stall_q <= '0;
    end else if (busy && at_l && !i_ppu_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_q;
`else
  assign o_stall_cnt = '0;
`endif

  assign o_busy      = busy;
  assign o_mode      = mode_q;
  assign o_findmax   = (state == MAX);
  assign o_mac_en    = issue;
  assign o_acc_we    = issue;
  assign o_psum_clr  = busy && (a_cnt == '0);
  assign o_acc_addr  = b_cnt;
  assign o_a_addr    = A_AW'(a_cnt) + A_AW'(row_cnt) * A_AW'(K_STEPS);
  assign o_b_addr    = B_AW'(b_cnt) + B_AW'(col_cnt) * B_AW'(B_STEPS) + B_AW'(a_cnt) * B_AW'(B_KSTRIDE);
  assign o_ppu_start = ppu_start_q;
  assign o_tile_done = tile_done_q;
  assign o_mtrx_done = mtrx_done_q;

endmodule

// File: tb/tb_mm_seq.sv
// tb/tb_mm_seq.sv - scoreboard bench for mm_seq
`ifndef INT4_VSQ
`define INT4_VSQ 2'd3
`endif

module tb_mm_seq;

  localparam logic [1:0] VSQ = `INT4_VSQ;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [4:0]  row_tiles;
  logic [4:0]  col_tiles;
  logic        abort;
  logic        ppu_ready;
  logic        busy;
  logic [1:0]  mode_o;
  logic        findmax;
  logic [6:0]  a_addr;
  logic [10:0] b_addr;
  logic        mac_en;
  logic        psum_clr;
  logic        acc_we;
  logic [3:0]  acc_addr;
  logic        ppu_start;
  logic        tile_done;
  logic        mtrx_done;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  mm_seq dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_row_tiles(row_tiles), .i_col_tiles(col_tiles), .i_abort(abort),
    .i_ppu_ready(ppu_ready), .o_busy(busy), .o_mode(mode_o), .o_findmax(findmax),
    .o_a_addr(a_addr), .o_b_addr(b_addr), .o_mac_en(mac_en), .o_psum_clr(psum_clr),
    .o_acc_we(acc_we), .o_acc_addr(acc_addr), .o_ppu_start(ppu_start),
    .o_tile_done(tile_done), .o_mtrx_done(mtrx_done), .o_stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [6:0]  a;
    logic [10:0] b;
    logic        clr;
    logic [3:0]  acc;
  } step_t;

  typedef struct packed {
    logic tile;
    logic mtrx;
    logic busy;
  } pulse_t;

  step_t  step_q[$];
  pulse_t pulse_q[$];
  int checks = 0;
  int errors = 0;
  int ppu_seen = 0;
  int tile_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected step stream and completion pulses for one job.
  task automatic push_job(input bit vsq, input int rt, input int ct);
    int passes;
    step_t s;
    pulse_t p;
    passes = vsq ? 1 : 2;
    for (int ps = 0; ps < passes; ps++) begin
      for (int r = 0; r <= rt; r++) begin
        for (int c = 0; c <= ct; c++) begin
          for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 16; b++) begin
              s.a   = 7'(a + r * 4);
              s.b   = 11'(b + c * 16 + a * 512);
              s.clr = (a == 0);
              s.acc = 4'(b);
              step_q.push_back(s);
            end
          end
          p.tile = (ps == passes - 1);
          p.mtrx = (ps == passes - 1) && (r == rt) && (c == ct);
          p.busy = !p.mtrx;
          pulse_q.push_back(p);
        end
      end
    end
  endtask

  // Monitor: pops one expected step per issued cycle and one pulse record per o_ppu_start.
  always @(negedge clk) begin
    step_t  e;
    pulse_t pe;
    if (!rst) begin
      if (mac_en) begin
        if (step_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL step_unexpected: got a=%0d b=%0d expected no step", a_addr, b_addr);
        end else begin
          e = step_q.pop_front();
          chk("a_addr", 32'(a_addr), 32'(e.a));
          chk("b_addr", 32'(b_addr), 32'(e.b));
          chk("psum_clr", 32'(psum_clr), 32'(e.clr));
          chk("acc_addr", 32'(acc_addr), 32'(e.acc));
          chk("acc_we", 32'(acc_we), 32'd1);
        end
      end
      if (ppu_start) begin
        ppu_seen++;
        if (tile_done) tile_seen++;
        if (pulse_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pulse_unexpected: got ppu_start=1 expected 0");
        end else begin
          pe = pulse_q.pop_front();
          chk("tile_done", 32'(tile_done), 32'(pe.tile));
          chk("mtrx_done", 32'(mtrx_done), 32'(pe.mtrx));
          chk("busy_at_pulse", 32'(busy), 32'(pe.busy));
        end
      end else if (tile_done || mtrx_done) begin
        checks++; errors++;
        $display("FAIL stray_done: got tile=%0d mtrx=%0d expected 0", tile_done, mtrx_done);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into the first issue cycle.
  task automatic start_job(input logic [1:0] m, input logic [4:0] rt, input logic [4:0] ct);
    mode = m; row_tiles = rt; col_tiles = ct; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, t0;
    rst = 1'b1; start = 1'b0; mode = 2'd0; row_tiles = '0; col_tiles = '0;
    abort = 1'b0; ppu_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mode", 32'(mode_o), 0);
    chk("rst_a_addr", 32'(a_addr), 0);
    chk("rst_b_addr", 32'(b_addr), 0);
    chk("rst_mac_en", 32'(mac_en), 0);
    chk("rst_psum_clr", 32'(psum_clr), 0);
    chk("rst_stall", stall_cnt, 0);
    tick(2);

    // single VSQ tile
    p0 = ppu_seen; t0 = tile_seen;
    push_job(1'b1, 0, 0);
    start_job(VSQ, 5'd0, 5'd0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_findmax", 32'(findmax), 0);
    chk("t1_mac_en", 32'(mac_en), 1);
    chk("t1_mode", 32'(mode_o), 32'(VSQ));
    tick(16);
    chk("t1_b17", 32'(b_addr), 512);
    chk("t1_clr17", 32'(psum_clr), 0);
    tick(48);
    chk("t1_ppu", 32'(ppu_start), 1);
    chk("t1_tile", 32'(tile_done), 1);
    chk("t1_mtrx", 32'(mtrx_done), 1);
    chk("t1_busy_end", 32'(busy), 0);
    tick(2);
    chk("t1_ppu_cnt", 32'(ppu_seen - p0), 1);

    // non-VSQ 2x2: MAX pass then CALC pass
    p0 = ppu_seen; t0 = tile_seen;
    push_job(1'b0, 1, 1);
    start_job(2'd0, 5'd1, 5'd1);
    chk("t2_findmax", 32'(findmax), 1);
    tick(256);
    chk("t2_calc_findmax", 32'(findmax), 0);
    chk("t2_calc_busy", 32'(busy), 1);
    chk("t2_calc_a", 32'(a_addr), 0);
    tick(256);
    chk("t2_mtrx_513", 32'(mtrx_done), 1);
    tick(2);
    chk("t2_ppu_cnt", 32'(ppu_seen - p0), 8);
    chk("t2_tile_cnt", 32'(tile_seen - t0), 4);

    // PPU back-pressure for 5 cycles at the last step
    ppu_ready = 1'b0;
    push_job(1'b1, 0, 0);
    start_job(VSQ, 5'd0, 5'd0);
    tick(63);
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall_mac", 32'(mac_en), 0);
      chk("t3_stall_we", 32'(acc_we), 0);
      chk("t3_stall_b", 32'(b_addr), 1551);
      chk("t3_stall_a", 32'(a_addr), 3);
      tick(1);
    end
    ppu_ready = 1'b1;
    #1;
    chk("t3_l_issue", 32'(mac_en), 1);
`ifdef MM_SEQ_PERF_EN
    chk("t3_stall_cnt", stall_cnt, 5);
`else
    chk("t3_stall_cnt", stall_cnt, 0);
`endif
    tick(1);
    chk("t3_mtrx", 32'(mtrx_done), 1);
    tick(2);

    // abort mid-tile, then restart
    push_job(1'b1, 0, 0);
    start_job(VSQ, 5'd0, 5'd0);
    tick(19);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    step_q.delete();
    pulse_q.delete();
    chk("t4_busy", 32'(busy), 0);
    chk("t4_mac_en", 32'(mac_en), 0);
    tick(70);
    push_job(1'b1, 0, 0);
    start_job(VSQ, 5'd0, 5'd0);
    chk("t4_re_a", 32'(a_addr), 0);
    chk("t4_re_b", 32'(b_addr), 0);
    tick(64);
    chk("t4_mtrx", 32'(mtrx_done), 1);
    tick(2);

    // start while busy is ignored
    push_job(1'b1, 0, 0);
    start_job(VSQ, 5'd0, 5'd0);
    tick(9);
    start = 1'b1; mode = 2'd0; row_tiles = 5'd3;
    tick(1);
    start = 1'b0; row_tiles = 5'd0;
    chk("t5_mode_kept", 32'(mode_o), 32'(VSQ));
    tick(54);
    chk("t5_mtrx", 32'(mtrx_done), 1);
    tick(2);

    // reset mid-tile
    push_job(1'b1, 0, 0);
    start_job(VSQ, 5'd0, 5'd0);
    tick(29);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    step_q.delete();
    pulse_q.delete();
    chk("t6_busy", 32'(busy), 0);
    chk("t6_mac_en", 32'(mac_en), 0);
    chk("t6_a", 32'(a_addr), 0);
    chk("t6_b", 32'(b_addr), 0);
    chk("t6_acc", 32'(acc_addr), 0);
    chk("t6_clr", 32'(psum_clr), 0);
    chk("t6_mode", 32'(mode_o), 0);
    chk("t6_ppu", 32'(ppu_start), 0);
    chk("t6_stall", stall_cnt, 0);
    tick(80);

    chk("steps_left", 32'(step_q.size()), 0);
    chk("pulses_left", 32'(pulse_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_seq.md
# mm_seq

Parametrised matrix-multiply tile sequencer, successor to the fixed 32×32-tile controller. It walks output tiles row-major and issues A/B buffer addresses, MAC psum-clear and accumulator write controls to external RAMs, MAC lanes and the accumulator. Matrix size is runtime-programmable, the PPU hand-off has back-pressure, and jobs can be aborted. It sits between the top-level job FSM and the MAC/accumulator/PPU datapath.

## Interface
- B_STEPS, 16: output columns per tile; this is also the accumulator depth.
- K_STEPS, 4: K-chunks per tile; each chunk is one A-buffer word.
- ROW_MAX, 32: maximum row tiles.
- COL_MAX, 32: maximum column tiles.
- B_KSTRIDE, 512: B-address stride per K-chunk.
- A_AW, 7: A-address width.
- B_AW, 11: B-address width.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  job request; sampled only in IDLE.
- i_mode  in  2  datapath mode; latched at start.
- i_row_tiles  in  clog2(ROW_MAX)  row-tile count minus 1; latched at start.
- i_col_tiles  in  clog2(COL_MAX)  column-tile count minus 1; latched at start.
- i_abort  in  1  cancel the current job.
- i_ppu_ready  in  1  PPU can accept a completed tile.
- o_busy  out  1  state is not IDLE.
- o_mode  out  2  latched mode.
- o_findmax  out  1  state is MAX.
- o_a_addr  out  A_AW  A-buffer address.
- o_b_addr  out  B_AW  B-buffer address.
- o_mac_en  out  1  a step is issued this cycle.
- o_psum_clr  out  1  MAC uses zero psum (a_cnt == 0).
- o_acc_we  out  1  accumulator write enable.
- o_acc_addr  out  clog2(B_STEPS)  accumulator read/write address.
- o_ppu_start  out  1  tile complete; PPU may read the accumulator.
- o_tile_done  out  1  CALC tile complete.
- o_mtrx_done  out  1  job complete.
- o_stall_cnt  out  32  PPU-stall cycles (see Configuration).

## Operation
- States: IDLE, MAX, CALC.
- IDLE → CALC on i_start when i_mode == `INT4_VSQ`.
- IDLE → MAX on i_start for any other mode.
- MAX → CALC when the last step of the last tile issues.
- CALC → IDLE when the last step of the last tile issues.
- Any state → IDLE on i_abort. i_abort has priority over all other events.
- On start: latch mode and tile counts; clear all counters.
- i_start while busy is ignored.
- Counter b_cnt runs 0..B_STEPS-1 and increments each issued step.
- Counter a_cnt runs 0..K_STEPS-1 and increments on b_cnt wrap.
- Counter col_cnt runs 0..i_col_tiles and increments on a_cnt wrap.
- Counter row_cnt runs 0..i_row_tiles and increments on col_cnt wrap.
- On state change MAX→CALC, all counters wrap to 0.
- Addresses are combinational from registered counters, truncated to port width:
  - o_a_addr = a_cnt + row_cnt·K_STEPS.
  - o_b_addr = b_cnt + col_cnt·B_STEPS + a_cnt·B_KSTRIDE.
  - o_acc_addr = b_cnt.
- Last step L: b_cnt = B_STEPS-1 and a_cnt = K_STEPS-1.
- issue = busy AND NOT (at L AND NOT i_ppu_ready).
- o_mac_en = o_acc_we = issue.
- o_psum_clr = (a_cnt == 0) AND busy.
- When issue is 0, counters hold.
- MAX pass: identical address walk, but o_tile_done is not pulsed.

## Timing
- Reset values:
  - State IDLE; all counters 0; latched mode 0; latched tile counts 0.
  - All outputs 0, including o_stall_cnt.
- Start latency: i_start high in IDLE at edge n → first step issues in cycle n+1 with all addresses 0.
- Each issued step is one cycle. A tile with no stalls takes B_STEPS·K_STEPS cycles.
- o_ppu_start is a registered 1-cycle pulse, in the cycle after L issues; this applies in both MAX and CALC.
- o_tile_done (CALC only) pulses in the same cycle as o_ppu_start.
- o_mtrx_done pulses in that same cycle, for the final CALC tile only. o_busy is already 0 in that cycle.
- Stall: while at L with i_ppu_ready = 0, hold all outputs, with o_mac_en = o_acc_we = 0. L issues in the first cycle i_ppu_ready = 1.
- i_ppu_ready is ignored when not at L.
- Abort at edge n: from cycle n+1, o_busy = 0 and no done pulses are produced. Pulses already registered at edge n still appear.
- Reset mid-job: returns to IDLE on the next edge; no done pulse.

## Configuration
- Macro: MM_SEQ_PERF_EN.
- Defined:
  - o_stall_cnt increments each busy cycle where at L AND NOT i_ppu_ready.
  - Clears on start.
  - Saturates at 2^32-1.
  - Holds its value in IDLE.
- Undefined: o_stall_cnt is tied to 0 and no counter logic is compiled in.

## Test plan
- Reset, then i_start with mode `INT4_VSQ`, i_row_tiles = 0, i_col_tiles = 0, i_ppu_ready = 1 → directly CALC; 64 issue cycles; o_b_addr sequence 0..15, 512..527, 1024..1039, 1536..1551; o_psum_clr high for the first 16 cycles; one cycle later o_ppu_start, o_tile_done and o_mtrx_done all high.
- Non-VSQ mode with 2×2 tiles → MAX pass of 256 cycles with 4 o_ppu_start pulses and no o_tile_done; then CALC pass with 4 o_tile_done pulses; final o_mtrx_done at cycle 513; o_a_addr for row 1 = 4..7.
- Hold i_ppu_ready = 0 for 5 cycles at L → counters frozen, o_acc_we = 0 for 5 cycles, and o_stall_cnt = 5 with MM_SEQ_PERF_EN defined (0 without); L issues when ready rises.
- Assert i_abort mid-tile → o_busy = 0 the next cycle, no o_mtrx_done; a new i_start then restarts with all addresses 0.
- i_start asserted while busy, and i_rst asserted in the middle of a tile → start ignored; reset returns to IDLE with all outputs 0 and no done pulse.
